// File: rtl/rv32i_v1.sv
// ============================================================================
//  Module   : rv32i_v1
//  Brief    : Single-cycle RV32I integer core with word-indexed PC and memories.
//             Optional macro RV32I_REGFILE_CLEAR_EN makes reset clear x1..x31.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module rv32i_v1 #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output logic        write,
    input  logic [31:0] data_in,
    output logic [31:0] data_addr,
    output logic [31:0] data_out,
    output logic [31:0] pc
);

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [2:0] c_F3_WORD   = 3'b010;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] rf_q [32];

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;

    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic signed [31:0] w_b_off;
    logic signed [31:0] w_j_off;

    logic [31:0] w_op_b;
    logic [4:0]  w_shamt;
    logic signed [31:0] w_sra_res;
    logic [31:0] w_alu;

    logic        w_br_legal;
    logic        w_br_taken;

    logic        w_rf_we;
    logic [31:0] w_rf_wdata;
    logic        w_mem_we;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_rs1    = instr[19:15];
    assign w_rs2    = instr[24:20];
    assign w_rd     = instr[11:7];

    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : rf_q[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : rf_q[w_rs2];

    assign w_imm_i = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_imm_u = {instr[31:12], 12'd0};
    assign w_imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Byte offsets in the encoding become word offsets for the word-indexed PC
    assign w_b_off = $signed(w_imm_b) >>> 2;
    assign w_j_off = $signed(w_imm_j) >>> 2;

    // Address/store data are driven for every instruction; only LW/SW care
    assign data_addr = w_rs1_val + ((w_opcode == c_OP_STORE) ? w_imm_s : w_imm_i);
    assign data_out  = w_rs2_val;
    assign write     = w_mem_we;
    assign pc        = pc_q;

    assign w_op_b    = (w_opcode == c_OP_REG) ? w_rs2_val : w_imm_i;
    assign w_shamt   = w_op_b[4:0];
    assign w_sra_res = $signed(w_rs1_val) >>> w_shamt;

    always_comb begin
        w_alu = 32'd0;
        case (w_funct3)
            3'b000: w_alu = ((w_opcode == c_OP_REG) && instr[30]) ? (w_rs1_val - w_op_b)
                                                                   : (w_rs1_val + w_op_b);
            3'b001: w_alu = w_rs1_val << w_shamt;
            3'b010: w_alu = {31'd0, $signed(w_rs1_val) < $signed(w_op_b)};
            3'b011: w_alu = {31'd0, w_rs1_val < w_op_b};
            3'b100: w_alu = w_rs1_val ^ w_op_b;
            3'b101: w_alu = instr[30] ? w_sra_res : (w_rs1_val >> w_shamt);
            3'b110: w_alu = w_rs1_val | w_op_b;
            3'b111: w_alu = w_rs1_val & w_op_b;
            default: w_alu = 32'd0;
        endcase
    end

    always_comb begin
        w_br_legal = 1'b1;
        w_br_taken = 1'b0;
        case (w_funct3)
            3'b000: w_br_taken = (w_rs1_val == w_rs2_val);
            3'b001: w_br_taken = (w_rs1_val != w_rs2_val);
            3'b100: w_br_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
            3'b101: w_br_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            3'b110: w_br_taken = (w_rs1_val <  w_rs2_val);
            3'b111: w_br_taken = (w_rs1_val >= w_rs2_val);
            default: w_br_legal = 1'b0;
        endcase
    end

    always_comb begin
        pc_d       = pc_q + 32'd1;
        w_rf_we    = 1'b0;
        w_rf_wdata = w_alu;
        w_mem_we   = 1'b0;
        case (w_opcode)
            c_OP_LUI: begin
                w_rf_we    = 1'b1;
                w_rf_wdata = w_imm_u;
            end
            c_OP_AUIPC: begin
                w_rf_we    = 1'b1;
                w_rf_wdata = pc_q + w_imm_u;
            end
            c_OP_JAL: begin
                w_rf_we    = 1'b1;
                w_rf_wdata = pc_q + 32'd1;
                pc_d       = pc_q + w_j_off;
            end
            c_OP_JALR: begin
                w_rf_we    = 1'b1;
                w_rf_wdata = pc_q + 32'd1;
                pc_d       = w_rs1_val + w_imm_i;
            end
            c_OP_BRANCH: begin
                if (w_br_legal && w_br_taken) begin
                    pc_d = pc_q + w_b_off;
                end
            end
            c_OP_LOAD: begin
                if (w_funct3 == c_F3_WORD) begin
                    w_rf_we    = 1'b1;
                    w_rf_wdata = data_in;
                end
            end
            c_OP_STORE: begin
                if (w_funct3 == c_F3_WORD) begin
                    w_mem_we = 1'b1;
                end
            end
            c_OP_IMM, c_OP_REG: begin
                w_rf_we = 1'b1;
            end
            default: begin
                w_rf_we = 1'b0;
            end
        endcase
        if (rst) begin
            pc_d     = RESET_PC;
            w_rf_we  = 1'b0;
            w_mem_we = 1'b0;
        end
        if (w_rd == 5'd0) begin
            w_rf_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef RV32I_REGFILE_CLEAR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if (w_rf_we) begin
            rf_q[w_rd] <= w_rf_wdata;
        end
    end
`else
    // Without the clear option, reset only blocks the write (w_rf_we is gated)
    always_ff @(posedge clk) begin
        if (w_rf_we) begin
            rf_q[w_rd] <= w_rf_wdata;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv32i_v1.sv
// ============================================================================
//  Module   : tb_rv32i_v1
//  Brief    : Directed self-checking bench for rv32i_v1; registers are observed
//             by issuing SW probes and checking data_out.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rv32i_v1;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        write;
    logic [31:0] data_in;
    logic [31:0] data_addr;
    logic [31:0] data_out;
    logic [31:0] pc;

    logic [31:0] dmem [16];
    int total;
    int bad;

    rv32i_v1 #(.RESET_PC(32'd0)) dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .write     (write),
        .data_in   (data_in),
        .data_addr (data_addr),
        .data_out  (data_out),
        .pc        (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb data_in = dmem[data_addr[3:0]];

    always @(posedge clk) begin
        if (write) dmem[data_addr[3:0]] <= data_out;
    end

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present one instruction, clock it, and check the resulting pc
    task automatic step(input string tag, input logic [31:0] w, input logic [31:0] npc);
        instr = w;
        #1;
        @(posedge clk);
        #1;
        chk(tag, pc, npc);
    endtask

    // SW xr,0(x0): data_out exposes the register value
    task automatic probe(input string tag, input logic [4:0] r, input logic [31:0] exp,
                         input logic [31:0] npc);
        instr = enc_s(32'd0, r, 5'd0, 3'b010);
        #1;
        chk(tag, data_out, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 16; i++) dmem[i] = 32'd0;

        // Reset: write must stay low even with SW on the bus
        rst   = 1'b1;
        instr = enc_s(32'd3, 5'd1, 5'd0, 3'b010);
        @(posedge clk);
        #1;
        chk("reset_pc", pc, 32'd0);
        chk("reset_write", {31'd0, write}, 32'd0);
        rst = 1'b0;
        #1;
        chk("pc_after_reset", pc, 32'd0);

        step("addi_x1", enc_i(32'd5, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'd1);
        step("addi_x2", enc_i(32'hFFFFFFF9, 5'd1, 3'b000, 5'd2, 7'b0010011), 32'd2);
        step("sltiu_x3", enc_i(32'd1, 5'd2, 3'b011, 5'd3, 7'b0010011), 32'd3);
        probe("x1", 5'd1, 32'd5, 32'd4);
        probe("x2", 5'd2, 32'hFFFFFFFE, 32'd5);
        probe("x3", 5'd3, 32'd0, 32'd6);

        // SW x1,3(x0) then LW x4,3(x0)
        instr = enc_s(32'd3, 5'd1, 5'd0, 3'b010);
        #1;
        chk("sw_write", {31'd0, write}, 32'd1);
        chk("sw_addr", data_addr, 32'd3);
        chk("sw_data", data_out, 32'd5);
        @(posedge clk);
        #1;
        chk("sw_pc", pc, 32'd7);
        instr = enc_i(32'd3, 5'd0, 3'b010, 5'd4, 7'b0000011);
        #1;
        chk("lw_write", {31'd0, write}, 32'd0);
        chk("lw_addr", data_addr, 32'd3);
        @(posedge clk);
        #1;
        probe("x4", 5'd4, 32'd5, 32'd9);
        step("nop_zero_word", 32'd0, 32'd10);

        // Branches
        step("beq_taken", enc_b(32'd8, 5'd1, 5'd1, 3'b000), 32'd12);
        step("bne_not", enc_b(32'd8, 5'd1, 5'd1, 3'b001), 32'd13);
        step("blt_taken", enc_b(32'd8, 5'd1, 5'd2, 3'b100), 32'd15);
        step("bltu_not", enc_b(32'd8, 5'd1, 5'd2, 3'b110), 32'd16);
        step("bgeu_taken", enc_b(32'd12, 5'd1, 5'd2, 3'b111), 32'd19);
        step("bne_back", enc_b(32'hFFFFFFF8, 5'd2, 5'd1, 3'b001), 32'd17);
        step("jal_x0", enc_j(32'd12, 5'd0), 32'd20);

        // JAL / JALR
        step("jal_x5", enc_j(32'd16, 5'd5), 32'd24);
        probe("x5", 5'd5, 32'd21, 32'd25);
        step("jalr", enc_i(32'd0, 5'd5, 3'b000, 5'd0, 7'b1100111), 32'd21);
        probe("x0_after_jalr", 5'd0, 32'd0, 32'd22);

        // Shifts, x0 writes, illegal encodings
        step("srai", enc_i(32'h401, 5'd2, 3'b101, 5'd6, 7'b0010011), 32'd23);
        probe("x6", 5'd6, 32'hFFFFFFFF, 32'd24);
        step("addi_x0", enc_i(32'd9, 5'd0, 3'b000, 5'd0, 7'b0010011), 32'd25);
        probe("x0", 5'd0, 32'd0, 32'd26);
        step("addi_x7", enc_i(32'd1, 5'd0, 3'b000, 5'd7, 7'b0010011), 32'd27);
        step("lb_illegal", enc_i(32'd3, 5'd0, 3'b000, 5'd7, 7'b0000011), 32'd28);
        instr = enc_s(32'd3, 5'd1, 5'd0, 3'b001);
        #1;
        chk("sh_no_write", {31'd0, write}, 32'd0);
        @(posedge clk);
        #1;
        probe("x7_kept", 5'd7, 32'd1, 32'd30);
        step("sub_x8", {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd8, 7'b0110011}, 32'd31);
        probe("x8", 5'd8, 32'd7, 32'd32);
        step("auipc_x10", {20'h00001, 5'd10, 7'b0010111}, 32'd33);
        probe("x10", 5'd10, 32'h00001020, 32'd34);
        step("lui_x11", {20'hABCDE, 5'd11, 7'b0110111}, 32'd35);
        probe("x11", 5'd11, 32'hABCDE000, 32'd36);
        step("sll_x9", {7'b0000000, 5'd1, 5'd1, 3'b001, 5'd9, 7'b0110011}, 32'd37);
        probe("x9", 5'd9, 32'd160, 32'd38);
        step("sra_x12", {7'b0100000, 5'd1, 5'd2, 3'b101, 5'd12, 7'b0110011}, 32'd39);
        probe("x12", 5'd12, 32'hFFFFFFFF, 32'd40);
        step("slt_x13", {7'b0000000, 5'd1, 5'd2, 3'b010, 5'd13, 7'b0110011}, 32'd41);
        probe("x13", 5'd13, 32'd1, 32'd42);

        // Mid-run reset suppresses the register write
        rst   = 1'b1;
        instr = enc_i(32'd99, 5'd0, 3'b000, 5'd1, 7'b0010011);
        #1;
        @(posedge clk);
        #1;
        chk("midrun_reset_pc", pc, 32'd0);
        rst = 1'b0;
        probe("x1_after_reset", 5'd1, 32'd5, 32'd1);
        chk("pc_after_probe", pc, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
